adc_sample_sequencer: RTL and testbench

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

---
 rtl/adc_sample_sequencer_pkg.sv | 16 +
 rtl/adc_sample_sequencer_if.sv | 11 +
 rtl/adc_sample_sequencer_sample_fifo.sv | 56 +++++
 rtl/adc_sample_sequencer.sv | 141 ++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sample_sequencer_pkg.sv
// Shared types and default sizing for the ADC sample sequencer.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        GAP,
        WAIT
    } seq_state_t;

    localparam int DEF_N_BITS     = 10;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_PERIOD_W   = 16;
    localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Result stream from the sequencer to its consumer (valid/ready handshake).
interface adc_sample_sequencer_if import adc_seq_pkg::*; #(
    parameter int N_BITS = DEF_N_BITS
);
    logic [N_BITS-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/adc_sample_sequencer_sample_fifo.sv
// First-word-fall-through result buffer; a push into a full buffer is
// accepted only when the head is popped in the same cycle.
module sample_fifo import adc_seq_pkg::*; #(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [N_BITS-1:0]             push_data,
    input  logic                          pop_ready,
    output logic [N_BITS-1:0]             head_data,
    output logic                          head_valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          drop
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              pop;
    logic              push_ok;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign head_valid = (count != '0);
    assign pop        = head_valid && pop_ready;
    assign push_ok    = push && (!full || pop);
    assign drop       = push && full && !pop;
    // Head reads as zero while empty so reset leaves sample_data at 0.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign level      = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces a SAR converter (hold, wait for eoc, gap, programmable wait) and
// buffers results. Define ADC_SEQ_AVG_EN to push the mean of every 4 results.
module adc_sample_sequencer import adc_seq_pkg::*; #(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [PERIOD_W-1:0]          period,
    input  logic                         clear_err,
    output logic                         hold_digital,
    input  logic                         eoc,
    input  logic [N_BITS-1:0]            result_digital,
    adc_sample_sequencer_if.master       stream,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic                         timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t          state;
    logic [TW-1:0]       conv_cnt;
    logic [PERIOD_W-1:0] wait_cnt;
    logic                conv_done;
    logic                conv_abort;
    logic                push;
    logic [N_BITS-1:0]   push_data;
    logic                drop;

    assign conv_done  = (state == CONVERT) && eoc;
    assign conv_abort = (state == CONVERT) && !eoc && (conv_cnt == TW'(TIMEOUT - 1));

`ifdef ADC_SEQ_AVG_EN
    logic [N_BITS+1:0] acc;
    logic [1:0]        acc_n;
    logic [N_BITS+1:0] acc_sum;

    function automatic logic [N_BITS-1:0] avg4(input logic [N_BITS+1:0] sum);
        return sum[N_BITS+1:2];
    endfunction

    assign acc_sum   = acc + (N_BITS+2)'(result_digital);
    assign push      = conv_done && (acc_n == 2'd3);
    assign push_data = avg4(acc_sum);

    // A timeout discards the partial group so averages never span an abort.
    always_ff @(posedge clk) begin
        if (reset || conv_abort) begin
            acc   <= '0;
            acc_n <= '0;
        end else if (conv_done) begin
            acc   <= push ? '0 : acc_sum;
            acc_n <= acc_n + 2'd1;
        end
    end
`else
    assign push      = conv_done;
    assign push_data = result_digital;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_digital <= 1'b0;
            conv_cnt     <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= CONVERT;
                        hold_digital <= 1'b1;
                        conv_cnt     <= '0;
                    end
                end
                CONVERT: begin
                    if (conv_done || conv_abort) begin
                        state        <= GAP;
                        hold_digital <= 1'b0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state    <= WAIT;
                    wait_cnt <= period;
                end
                WAIT: begin
                    // Count reaching zero is itself a WAIT cycle, so period=0 still waits once.
                    if (wait_cnt == '0) begin
                        if (enable) begin
                            state        <= CONVERT;
                            hold_digital <= 1'b1;
                            conv_cnt     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    hold_digital <= 1'b0;
                end
            endcase
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (drop)           overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (conv_abort)     timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

    sample_fifo #(
        .N_BITS     (N_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop_ready  (stream.sample_ready),
        .head_data  (stream.sample_data),
        .head_valid (stream.sample_valid),
        .level      (fifo_level),
        .drop       (drop)
    );

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: timeline-based reference model plus
// directed scenarios and a randomized run.
module tb_adc_sample_sequencer;
    localparam int NB    = 10;
    localparam int DEPTH = 4;
    localparam int PW    = 16;
    localparam int TO    = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          clear_err = 1'b0;
    logic          eoc = 1'b0;
    logic [PW-1:0] period = '0;
    logic [NB-1:0] result = '0;
    logic          hold;
    logic [2:0]    level;
    logic          overflow;
    logic          timeout_err;

    adc_sample_sequencer_if #(.N_BITS(NB)) sif ();

    always #5 clk = ~clk;

    adc_sample_sequencer #(
        .N_BITS     (NB),
        .FIFO_DEPTH (DEPTH),
        .PERIOD_W   (PW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .period         (period),
        .clear_err      (clear_err),
        .hold_digital   (hold),
        .eoc            (eoc),
        .result_digital (result),
        .stream         (sif),
        .fifo_level     (level),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: converter activity as a timeline of cycle numbers.
    int q[$];
    bit m_conv = 0;
    bit m_gap = 0;
    bit m_idle = 1;
    int m_age = 0;
    int m_decide = -1;
    int cyc = 0;
    bit m_ov = 0;
    bit m_to = 0;
`ifdef ADC_SEQ_AVG_EN
    int m_acc = 0;
    int m_n = 0;
`endif

    task automatic model_step();
        bit pop;
        bit has_push;
        bit set_ov;
        bit set_to;
        bit start;
        int pv;
        has_push = 0; set_ov = 0; set_to = 0; start = 0; pv = 0;
        if (reset) begin
            q.delete();
            m_conv = 0; m_gap = 0; m_idle = 1; m_decide = -1; m_age = 0;
            m_ov = 0; m_to = 0;
`ifdef ADC_SEQ_AVG_EN
            m_acc = 0; m_n = 0;
`endif
        end else begin
            pop = (q.size() > 0) && sif.sample_ready;
            if (m_conv) begin
                if (eoc) begin
`ifdef ADC_SEQ_AVG_EN
                    m_acc += int'(result);
                    m_n++;
                    if (m_n == 4) begin
                        has_push = 1; pv = m_acc / 4; m_acc = 0; m_n = 0;
                    end
`else
                    has_push = 1; pv = int'(result);
`endif
                    m_conv = 0; m_gap = 1;
                end else if (m_age == TO - 1) begin
                    set_to = 1; m_conv = 0; m_gap = 1;
`ifdef ADC_SEQ_AVG_EN
                    m_acc = 0; m_n = 0;
`endif
                end else begin
                    m_age++;
                end
            end else if (m_gap) begin
                m_gap = 0;
                m_decide = cyc + int'(period) + 1;
            end else if (m_decide >= 0) begin
                if (cyc == m_decide) begin
                    m_decide = -1;
                    if (enable) start = 1;
                    else m_idle = 1;
                end
            end else if (m_idle && enable) begin
                start = 1;
            end
            if (start) begin
                m_conv = 1; m_age = 0; m_idle = 0;
            end
            if (pop) void'(q.pop_front());
            if (has_push) begin
                if (q.size() < DEPTH) q.push_back(pv);
                else set_ov = 1;
            end
            m_ov = set_ov | (m_ov & !clear_err);
            m_to = set_to | (m_to & !clear_err);
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("hold", int'(hold), int'(m_conv));
            chk("valid", int'(sif.sample_valid), int'(q.size() > 0));
            chk("data", int'(sif.sample_data), (q.size() > 0) ? q[0] : 0);
            chk("level", int'(level), q.size());
            chk("overflow", int'(overflow), int'(m_ov));
            chk("timeout_err", int'(timeout_err), int'(m_to));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; eoc = 0; clear_err = 0; sif.sample_ready = 0;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic wait_hold(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (hold) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("wait_hold", int'(hold), 1);
    endtask

    task automatic one_conv(input int value, input bit rdy);
        bit ok;
        wait_hold(ok);
        tick();
        eoc = 1; result = NB'(value); sif.sample_ready = rdy;
        tick();
        eoc = 0; sif.sample_ready = 0;
    endtask

    bit ok;
    int n;
    int rdy_pct;

    initial begin
        sif.sample_ready = 0;
        do_reset();
        chk_on = 1;
        chk("R_hold", int'(hold), 0);
        chk("R_level", int'(level), 0);
        chk("R_data", int'(sif.sample_data), 0);

`ifndef ADC_SEQ_AVG_EN
        // Basic timing: 10-cycle conversion, period 3.
        do_reset();
        enable = 1; period = 3;
        wait_hold(ok);
        repeat (9) tick();
        chk("A_hold_high", int'(hold), 1);
        eoc = 1; result = 10'h2A5;
        tick();
        eoc = 0;
        chk("A_hold_fall", int'(hold), 0);
        chk("A_valid", int'(sif.sample_valid), 1);
        chk("A_data", int'(sif.sample_data), 'h2A5);
        n = 0;
        while (!hold && n < 50) begin
            n++;
            tick();
        end
        chk("A_gap_len", n, 5);

        // Overflow: five results into a 4-deep buffer with no consumer.
        do_reset();
        enable = 1; period = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                wait_hold(ok);
                tick();
                eoc = 1; result = 10'd5; enable = 0;
                tick();
                eoc = 0;
            end else begin
                one_conv(i, 0);
            end
        end
        repeat (4) tick();
        chk("B_level", int'(level), 4);
        chk("B_overflow", int'(overflow), 1);
        chk("B_model_level", q.size(), 4);
        chk("B_model_ov", int'(m_ov), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("B_pop", int'(sif.sample_data), i);
            sif.sample_ready = 1;
            tick();
            sif.sample_ready = 0;
        end
        chk("B_drained", int'(level), 0);

        // Full buffer, push and pop in the same cycle.
        do_reset();
        enable = 1; period = 0;
        for (int i = 1; i <= 4; i++) one_conv(i, 0);
        wait_hold(ok);
        tick();
        eoc = 1; result = 10'd5; sif.sample_ready = 1; enable = 0;
        tick();
        eoc = 0; sif.sample_ready = 0;
        repeat (3) tick();
        chk("C_level", int'(level), 4);
        chk("C_overflow", int'(overflow), 0);
        chk("C_head", int'(sif.sample_data), 2);

        // Timeout with clear_err held high: the set event wins.
        do_reset();
        enable = 1; period = 0;
        wait_hold(ok);
        enable = 0; clear_err = 1;
        n = 0;
        while (hold && n < 200) begin
            n++;
            tick();
        end
        clear_err = 0;
        chk("D_hold_len", n, 64);
        chk("D_timeout", int'(timeout_err), 1);
        chk("D_model_to", int'(m_to), 1);
        chk("D_level", int'(level), 0);
        clear_err = 1;
        tick();
        clear_err = 0;
        chk("D_cleared", int'(timeout_err), 0);

        // Reset three cycles into a conversion; a late eoc is ignored.
        do_reset();
        enable = 1;
        wait_hold(ok);
        enable = 0;
        repeat (3) tick();
        reset = 1;
        tick();
        chk("E_hold", int'(hold), 0);
        chk("E_valid", int'(sif.sample_valid), 0);
        chk("E_level", int'(level), 0);
        chk("E_data", int'(sif.sample_data), 0);
        reset = 0;
        eoc = 1; result = 10'h3FF;
        tick();
        eoc = 0;
        tick();
        chk("E_late_eoc", int'(level), 0);
        chk("E_hold_after", int'(hold), 0);
`else
        // Averaging: 100,101,102,104 -> 101.
        do_reset();
        enable = 1; period = 0;
        one_conv(100, 0);
        one_conv(101, 0);
        one_conv(102, 0);
        chk("V_partial", int'(level), 0);
        wait_hold(ok);
        tick();
        eoc = 1; result = 10'd104; enable = 0;
        tick();
        eoc = 0;
        repeat (3) tick();
        chk("V_level", int'(level), 1);
        chk("V_avg", int'(sif.sample_data), 101);
`endif

        // Randomized run against the model.
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) period = PW'($urandom_range(0, 3));
            if (c % 300 == 0) rdy_pct = $urandom_range(0, 100);
            enable = ($urandom % 16) != 0;
            eoc = ($urandom % 6) == 0;
            result = NB'($urandom);
            sif.sample_ready = $urandom_range(0, 99) < rdy_pct;
            clear_err = ($urandom % 50) == 0;
            reset = ($urandom % 700) == 0;
            tick();
        end
        reset = 0; enable = 0; eoc = 0; clear_err = 0; sif.sample_ready = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
